fp_sqrt_seq: RTL and testbench

- Sequential IEEE-754 floating-point square root with built-in special-case generation.
- Parametrised in exponent and mantissa width; default is single precision.
- Uses a restoring digit-by-digit root, one result bit per clock.
- Sits in the FP datapath next to the divider and uses the same valid/ready handshakes on input and output.

---
 rtl/fp_sqrt_seq.sv | 208 ++++++++++++++++++++
 tb/tb_fp_sqrt_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root: restoring digit-by-digit root, one result bit per clock, special cases in PREP.
// Latency: special operands 1 cycle after accept, normal operands N+2 cycles (N = MAN_W+1, or MAN_W+2 with rounding).
// Backpressure: result held with out_valid until out_ready; in_ready low from accept until the result is taken.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake, data_i = {sign, exp, frac}
//   out_valid/out_ready result handshake, data_o = square root
//   busy               high whenever the FSM is not in IDLE
//
// Build option: define FP_SQRT_ROUND_NEAREST_EN to compute one guard root bit and
// round to nearest; otherwise the fraction is truncated.

module fp_sqrt_seq #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int BIAS      = (2**(EXP_W-1))-1,
    parameter int BUS_WIDTH = 1+EXP_W+MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] data_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 busy
);

    localparam int W    = MAN_W + 2;        // widest root the datapath ever needs
`ifdef FP_SQRT_ROUND_NEAREST_EN
    localparam int N    = MAN_W + 2;        // integer bit + fraction + guard
`else
    localparam int N    = MAN_W + 1;        // integer bit + fraction
`endif
    localparam int RADW = 2 * W;
    localparam int REMW = W + 2;
    localparam int CNTW = $clog2(N + 1);

    localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIN, DONE} state_t;

    state_t state, state_nxt;

    logic [BUS_WIDTH-1:0] op_q;
    logic [RADW-1:0]      rad_q;
    logic [N-1:0]         root_q;
    logic [REMW-1:0]      rem_q;
    logic [CNTW-1:0]      cnt_q;
    logic [EXP_W-1:0]     exp_q;
    logic [BUS_WIDTH-1:0] data_q;

    // Operand fields
    logic             op_sign;
    logic [EXP_W-1:0] op_exp;
    logic [MAN_W-1:0] op_frac;
    logic             exp_ones, exp_zero, frac_zero;
    logic             special;
    logic [BUS_WIDTH-1:0] special_res;

    assign op_sign   = op_q[BUS_WIDTH-1];
    assign op_exp    = op_q[BUS_WIDTH-2:MAN_W];
    assign op_frac   = op_q[MAN_W-1:0];
    assign exp_ones  = &op_exp;
    assign exp_zero  = ~|op_exp;
    assign frac_zero = ~|op_frac;

    // Anything that is NaN, negative, zero/denormal or infinite skips the iteration.
    assign special = exp_ones | exp_zero | op_sign;

    always_comb begin
        special_res = '0;
        if (exp_ones && !frac_zero) begin
            special_res = '1;                                   // NaN
        end else if (op_sign && !exp_zero) begin
            special_res = '1;                                   // negative, incl. -inf
        end else if (exp_zero) begin
            special_res = {op_sign, {(BUS_WIDTH-1){1'b0}}};     // +-0, denormals flushed
        end else begin
            special_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; // +inf
        end
    end

    // Exponent halving: an odd unbiased exponent moves one factor of two into the radicand.
    logic signed [EXP_W:0] eu, eu_even, res_exp_full;
    logic [MAN_W:0]        mant;
    logic [RADW-1:0]       rad_init;

    assign eu           = $signed({1'b0, op_exp}) - BIAS_S;
    assign eu_even      = eu - $signed({{EXP_W{1'b0}}, eu[0]});
    assign res_exp_full = (eu_even >>> 1) + BIAS_S;
    assign mant         = {1'b1, op_frac};

    // Radicand is left-aligned so every iteration consumes the top bit pair.
    assign rad_init = eu[0] ? {mant, {(MAN_W+3){1'b0}}}
                            : {1'b0, mant, {(MAN_W+2){1'b0}}};

    // One restoring step: bring down the next pair and try subtracting {root, 01}.
    logic [REMW-1:0] rem_sh, trial_sub;
    logic [REMW:0]   trial;
    logic            trial_ok;

    assign rem_sh    = {rem_q[REMW-3:0], rad_q[RADW-1 -: 2]};
    assign trial_sub = REMW'({root_q, 2'b01});
    assign trial     = {1'b0, rem_sh} - {1'b0, trial_sub};
    assign trial_ok  = ~trial[REMW];

    // Final packing; the root MSB is always 1 (hidden bit) and is dropped.
    logic [BUS_WIDTH-1:0] fin_res;
    logic                 unused_bits;

`ifdef FP_SQRT_ROUND_NEAREST_EN
    logic             guard, sticky, round_up;
    logic [MAN_W+1:0] mant_sum;
    logic [EXP_W-1:0] exp_inc;

    assign guard    = root_q[0];
    assign sticky   = |rem_q;
    // Guard set with zero sticky would be an exact tie, which sqrt never produces.
    assign round_up = guard & (sticky | root_q[1]);
    assign mant_sum = {1'b0, root_q[N-1:1]} + (MAN_W+2)'(round_up);
    assign exp_inc  = exp_q + 1'b1;

    always_comb begin
        fin_res = {1'b0, exp_q, mant_sum[MAN_W-1:0]};
        if (mant_sum[MAN_W+1]) begin
            fin_res = {1'b0, exp_inc, {MAN_W{1'b0}}};
        end
    end

    assign unused_bits = &{1'b0, res_exp_full[EXP_W], mant_sum[MAN_W]};
`else
    assign fin_res     = {1'b0, exp_q, root_q[MAN_W-1:0]};
    assign unused_bits = &{1'b0, res_exp_full[EXP_W], root_q[MAN_W], rem_q[REMW-1 -: 2]};
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)     state_nxt = PREP;
            PREP: state_nxt = special ? DONE : ITER;
            ITER: if (cnt_q == '0)  state_nxt = FIN;
            FIN:  state_nxt = DONE;
            DONE: if (out_ready)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= data_i;
                    end
                end
                PREP: begin
                    if (special) begin
                        data_q <= special_res;
                    end else begin
                        rad_q  <= rad_init;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= CNTW'(N - 1);
                        exp_q  <= res_exp_full[EXP_W-1:0];
                    end
                end
                ITER: begin
                    rad_q  <= {rad_q[RADW-3:0], 2'b00};
                    rem_q  <= trial_ok ? trial[REMW-1:0] : rem_sh;
                    root_q <= {root_q[N-2:0], trial_ok};
                    cnt_q  <= cnt_q - 1'b1;
                end
                FIN: begin
                    data_q <= fin_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_o    = data_q;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
module tb_fp_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_o;
    logic        busy;

    int pass_cnt  = 0;
    int check_cnt = 0;

`ifdef FP_SQRT_ROUND_NEAREST_EN
    localparam bit RND      = 1'b1;
    localparam int NORM_LAT = 27;
`else
    localparam bit RND      = 1'b0;
    localparam int NORM_LAT = 26;
`endif

    fp_sqrt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Largest r with r*r <= x, found by setting bits greedily.
    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Single-precision reference: specials by rule, normals via integer sqrt of the scaled significand.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        int          eu;
        int          res_e;
        logic [7:0]  e_out;
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        s = a[31];
        e = a[30:23];
        f = a[22:0];
        if (e == 8'hFF && f != 23'd0) return 32'hFFFFFFFF;
        if (s && e != 8'd0)           return 32'hFFFFFFFF;
        if (e == 8'd0)                return {s, 31'd0};
        if (e == 8'hFF)               return 32'h7F800000;
        eu = int'(e) - 127;
        m  = {40'd0, 1'b1, f};
        x  = m << (RND ? 25 : 23);
        if (eu % 2 != 0) begin
            x  = x << 1;
            eu = eu - 1;
        end
        res_e = eu / 2 + 127;
        r = isqrt(x);
        if (RND) begin
            // r carries one extra bit; its LSB says whether the true root is past the halfway point
            r = r[0] ? (r >> 1) + 64'd1 : (r >> 1);
            if (r == (64'd1 << 24)) begin
                res_e = res_e + 1;
                r     = 64'd1 << 23;
            end
        end
        e_out = 8'(res_e);
        return {1'b0, e_out, r[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] a);
        return a[31] || a[30:23] == 8'hFF || a[30:23] == 8'h00;
    endfunction

    // Drives one operation; returns the result and the number of edges from accept to out_valid.
    task automatic do_op(input logic [31:0] a, output logic [31:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        data_i   = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_i   = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = data_o;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_i    = 32'd0;
        #2;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (data_o !== 32'd0) $display("FAIL reset_data_o got %h want 00000000", data_o); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] vin  [12];
        logic [31:0] vexp [12];
        logic [31:0] res;
        int          lat;
        int          want_lat;
        vin  = '{32'h40800000, 32'h41100000, 32'h40A00000, 32'h3E800000,
                 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h7FC00000,
                 32'h80000000, 32'h7F800000, 32'h00000001, 32'hFF800000};
        vexp = '{32'h40000000, 32'h40400000, (RND ? 32'h400F1BBD : 32'h400F1BBC), 32'h3F000000,
                 32'h3F800000, 32'h3FB504F3, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h80000000, 32'h7F800000, 32'h00000000, 32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) begin
            do_op(vin[i], res, lat);
            want_lat = is_special(vin[i]) ? 1 : NORM_LAT;
            check_cnt++;
            if (res !== vexp[i]) $display("FAIL directed_result in=%h got %h want %h", vin[i], res, vexp[i]);
            else pass_cnt++;
            check_cnt++;
            if (lat != want_lat) $display("FAIL directed_latency in=%h got %0d want %0d", vin[i], lat, want_lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] res;
        logic [31:0] want;
        logic [7:0]  e;
        logic [22:0] f;
        int          lat;
        int          want_lat;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
            end else begin
                e = 8'($urandom_range(1, 254));
                f = 23'($urandom);
                a = {1'b0, e, f};
            end
            want     = ref_sqrt(a);
            want_lat = is_special(a) ? 1 : NORM_LAT;
            do_op(a, res, lat);
            check_cnt++;
            if (res !== want) $display("FAIL random_result in=%h got %h want %h", a, res, want);
            else pass_cnt++;
            check_cnt++;
            if (lat != want_lat) $display("FAIL random_latency in=%h got %0d want %0d", a, lat, want_lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int          w;
        int          lat;
        logic [31:0] res;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        data_i   = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_cnt++;
        if (lat != NORM_LAT) $display("FAIL bp_latency got %0d want %0d", lat, NORM_LAT); else pass_cnt++;
        // Hold the result while a competing operand is offered.
        in_valid = 1'b1;
        data_i   = 32'h40800000;
        for (int i = 0; i < 5; i++) begin
            check_cnt++;
            if (out_valid !== 1'b1) $display("FAIL bp_out_valid cycle=%0d got %b want 1", i, out_valid); else pass_cnt++;
            check_cnt++;
            if (data_o !== 32'h3FB504F3) $display("FAIL bp_data_o cycle=%0d got %h want 3FB504F3", i, data_o); else pass_cnt++;
            check_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle=%0d got %b want 0", i, in_ready); else pass_cnt++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", out_valid); else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL bp_stale_accept busy got %b want 0", busy); else pass_cnt++;
        do_op(32'h3F800000, res, lat);
        check_cnt++;
        if (res !== 32'h3F800000) $display("FAIL bp_next_result got %h want 3F800000", res); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        int          w;
        int          lat;
        logic [31:0] res;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        data_i   = 32'h40800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL midop_busy_before got %b want 1", busy); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL midop_in_ready got %b want 1", in_ready); else pass_cnt++;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL midop_out_valid got %b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL midop_busy got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (data_o !== 32'd0) $display("FAIL midop_data_o got %h want 00000000", data_o); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midop_no_result got %b want 0", out_valid); else pass_cnt++;
        do_op(32'h40800000, res, lat);
        check_cnt++;
        if (res !== 32'h40000000) $display("FAIL midop_next_result got %h want 40000000", res); else pass_cnt++;
        check_cnt++;
        if (lat != NORM_LAT) $display("FAIL midop_next_latency got %0d want %0d", lat, NORM_LAT); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
